// File: rtl/l2_cache.sv
// Set-associative, write-back, write-allocate L2 cache serving whole-block
// requests from L1 one at a time, with round-robin replacement per set.
module l2_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_SIZE = 4096,
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_WAYS   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            l1_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_in,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_out,
    input  logic                             l1_read,
    input  logic                             l1_write,
    output logic                             l1_ready,
    output logic                             l1_hit,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
    output logic                             mem_read,
    output logic                             mem_write,
    input  logic                             mem_ready
);
    localparam int BW       = BLOCK_SIZE * DATA_WIDTH;
    localparam int NUM_SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int OFF_BITS = $clog2(BLOCK_SIZE);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = ADDR_WIDTH - OFF_BITS - IDX_BITS;
    localparam int WAY_BITS = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

    state_t                state_reg, state_next;
    logic                  req_write_reg;
    logic [TAG_BITS-1:0]   req_tag_reg;
    logic [IDX_BITS-1:0]   req_idx_reg;
    logic [BW-1:0]         req_data_reg;
    logic [WAY_BITS-1:0]   victim_reg;
    logic [NUM_SETS-1:0]   valid_reg [NUM_WAYS];
    logic [NUM_SETS-1:0]   dirty_reg [NUM_WAYS];
    logic [WAY_BITS-1:0]   rr_reg [NUM_SETS];

    logic [IDX_BITS-1:0]   rd_idx;
    logic [TAG_BITS-1:0]   tag_rd [NUM_WAYS];
    logic [BW-1:0]         data_rd [NUM_WAYS];
    logic [NUM_WAYS-1:0]   hit_vec, valid_vec;
    logic [WAY_BITS-1:0]   hit_way, free_way, victim, wr_way;
    logic                  any_free, victim_dirty;
    logic [TAG_BITS-1:0]   victim_tag;
    logic [BW-1:0]         victim_data, wr_data, resp_data;
    logic                  wr_en, wr_from_mem, wr_dirty, clr_dirty, rr_adv, ld_victim;
    logic                  ld_addr, ld_wb_data, resp_load, resp_hit;
    logic [ADDR_WIDTH-1:0] addr_val, fill_addr;
    logic [OFF_BITS-1:0]   unused_offset;

    assign unused_offset = l1_addr[OFF_BITS-1:0];
    // Tag/data RAMs are read every cycle; in IDLE the read follows the incoming
    // address so the set is ready for the tag compare in LOOKUP.
    assign rd_idx    = (state_reg == IDLE) ? l1_addr[OFF_BITS +: IDX_BITS] : req_idx_reg;
    assign wr_data   = wr_from_mem ? mem_data_in : req_data_reg;
    assign fill_addr = {req_tag_reg, req_idx_reg, {OFF_BITS{1'b0}}};

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        logic [TAG_BITS-1:0] tag_mem [NUM_SETS];
        logic [BW-1:0]       data_mem [NUM_SETS];
        logic [TAG_BITS-1:0] tag_q;
        logic [BW-1:0]       data_q;

        always_ff @(posedge clk) begin
            if (wr_en && wr_way == WAY_BITS'(gi)) begin
                tag_mem[req_idx_reg]  <= req_tag_reg;
                data_mem[req_idx_reg] <= wr_data;
            end
            tag_q  <= tag_mem[rd_idx];
            data_q <= data_mem[rd_idx];
        end

        assign tag_rd[gi]    = tag_q;
        assign data_rd[gi]   = data_q;
        assign valid_vec[gi] = valid_reg[gi][req_idx_reg];
        assign hit_vec[gi]   = valid_vec[gi] && (tag_q == req_tag_reg);
    end

    always_comb begin
        hit_way  = '0;
        free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i])    hit_way  = WAY_BITS'(i);
            if (!valid_vec[i]) free_way = WAY_BITS'(i);
        end
        any_free     = |(~valid_vec);
        victim       = any_free ? free_way : rr_reg[req_idx_reg];
        victim_dirty = !any_free && dirty_reg[victim][req_idx_reg];
        victim_tag   = tag_rd[victim];
        victim_data  = data_rd[victim];
    end

    always_comb begin
        state_next  = state_reg;
        wr_en       = 1'b0;
        wr_way      = victim_reg;
        wr_from_mem = 1'b0;
        wr_dirty    = 1'b0;
        clr_dirty   = 1'b0;
        rr_adv      = 1'b0;
        ld_victim   = 1'b0;
        ld_addr     = 1'b0;
        ld_wb_data  = 1'b0;
        addr_val    = fill_addr;
        resp_load   = 1'b0;
        resp_hit    = 1'b0;
        resp_data   = req_data_reg;
        case (state_reg)
            IDLE: begin
                if (l1_read || l1_write) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (|hit_vec) begin
                    resp_load  = 1'b1;
                    resp_hit   = 1'b1;
                    state_next = RESPOND;
                    if (req_write_reg) begin
                        wr_en    = 1'b1;
                        wr_way   = hit_way;
                        wr_dirty = 1'b1;
                    end else begin
                        resp_data = data_rd[hit_way];
                    end
                end else begin
                    ld_victim = 1'b1;
                    rr_adv    = !any_free;
                    if (victim_dirty) begin
                        ld_addr    = 1'b1;
                        ld_wb_data = 1'b1;
                        addr_val   = {victim_tag, req_idx_reg, {OFF_BITS{1'b0}}};
                        state_next = WRITEBACK;
                    end else if (!req_write_reg) begin
                        ld_addr    = 1'b1;
                        state_next = FILL;
                    end else begin
                        wr_en      = 1'b1;
                        wr_way     = victim;
                        wr_dirty   = 1'b1;
                        resp_load  = 1'b1;
                        state_next = RESPOND;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_write && mem_ready) begin
                    clr_dirty = 1'b1;
                    if (!req_write_reg) begin
                        ld_addr    = 1'b1;
                        state_next = FILL;
                    end else begin
                        wr_en      = 1'b1;
                        wr_dirty   = 1'b1;
                        resp_load  = 1'b1;
                        state_next = RESPOND;
                    end
                end
            end
            FILL: begin
                if (mem_read && mem_ready) begin
                    wr_en       = 1'b1;
                    wr_from_mem = 1'b1;
                    resp_load   = 1'b1;
                    resp_data   = mem_data_in;
                    state_next  = RESPOND;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_reg == IDLE && (l1_read || l1_write)) begin
            req_write_reg <= !l1_read;
            req_tag_reg   <= l1_addr[ADDR_WIDTH-1 -: TAG_BITS];
            req_idx_reg   <= l1_addr[OFF_BITS +: IDX_BITS];
            req_data_reg  <= l1_data_in;
        end
        if (ld_victim) victim_reg <= victim;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            l1_data_out  <= '0;
            l1_ready     <= 1'b0;
            l1_hit       <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_reg[w] <= '0;
                dirty_reg[w] <= '0;
            end
            for (int s = 0; s < NUM_SETS; s++) rr_reg[s] <= '0;
        end else begin
            state_reg <= state_next;
            l1_ready  <= resp_load;
            if (resp_load) begin
                l1_data_out <= resp_data;
                l1_hit      <= resp_hit;
            end
            if (ld_addr)    mem_addr     <= addr_val;
            if (ld_wb_data) mem_data_out <= victim_data;
            // Strobes rise on the first cycle spent in their state and drop on the accepting edge.
            mem_write <= (state_reg == WRITEBACK) && !(mem_write && mem_ready);
            mem_read  <= (state_reg == FILL) && !(mem_read && mem_ready);
            if (rr_adv) rr_reg[req_idx_reg] <= rr_reg[req_idx_reg] + 1'b1;
            if (clr_dirty) dirty_reg[victim_reg][req_idx_reg] <= 1'b0;
            if (wr_en) begin
                valid_reg[wr_way][req_idx_reg] <= 1'b1;
                dirty_reg[wr_way][req_idx_reg] <= wr_dirty;
            end
        end
    end
endmodule

// File: doc/l2_cache.md
# l2_cache

- Second-level, set-associative, write-back, write-allocate cache between the L1 cache and main memory.
- Serves whole-block read and write requests from L1, one at a time, over a request/ready handshake.
- On a miss it writes back a dirty victim, then fetches the missing block from memory.
- Round-robin replacement per set.

## Interface

Parameters:
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 32, word address width
- CACHE_SIZE, 4096, capacity in words
- BLOCK_SIZE, 16, words per block; the low clog2(BLOCK_SIZE) address bits select the word
- NUM_WAYS, 4, associativity; NUM_SETS = CACHE_SIZE/BLOCK_SIZE/NUM_WAYS

Ports:
- clk  in  1  clock; one clock domain; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- l1_addr  in  ADDR_WIDTH  request address (offset bits ignored)
- l1_data_in  in  BLOCK_SIZE×DATA_WIDTH  block written by L1
- l1_data_out  out  BLOCK_SIZE×DATA_WIDTH  block returned to L1
- l1_read  in  1  block read request
- l1_write  in  1  block write request
- l1_ready  out  1  one-cycle response pulse
- l1_hit  out  1  the response was a hit
- mem_addr  out  ADDR_WIDTH  block-aligned memory address
- mem_data_out  out  BLOCK_SIZE×DATA_WIDTH  write-back block
- mem_data_in  in  BLOCK_SIZE×DATA_WIDTH  fill block
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_ready  in  1  memory completion, sampled only in WRITEBACK or FILL

## Operation

Per-line state: tag, valid, dirty, data. Per-set state: rr_ptr of clog2(NUM_WAYS) bits.

Reset (rst_n=0 at an edge):
- All outputs clear to 0; state goes to IDLE.
- All valid, dirty and rr_ptr bits clear. Dirty data is discarded.
- Reset applies in any state, including mid-transaction.

IDLE:
- If l1_read or l1_write is high, latch address, op and l1_data_in, then go to LOOKUP. Read wins if both are high.
- Request inputs are ignored in every other state.

LOOKUP (one cycle): compare the latched tag against all ways of the set.
- Read hit: l1_data_out ← line data; l1_hit ← 1; go to RESPOND.
- Write hit: line data ← latched block; dirty ← 1; l1_data_out ← latched block; l1_hit ← 1; go to RESPOND.
- Miss, victim selection:
  - Victim is the lowest-numbered invalid way.
  - If every way is valid, the victim is way rr_ptr, and rr_ptr increments modulo NUM_WAYS.
- Miss, next state:
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise, read miss: go to FILL.
  - Otherwise, write miss: install the latched block (valid=1, dirty=1, new tag); l1_data_out ← latched block; l1_hit ← 0; go to RESPOND. No memory read.

WRITEBACK:
- mem_write=1; mem_addr = {victim tag, index, 0}; mem_data_out = victim data.
- On mem_ready: mem_write ← 0, dirty ← 0.
- Then a read goes to FILL; a write installs the block as in a write miss and goes to RESPOND.

FILL:
- mem_read=1; mem_addr = {latched tag, index, 0}.
- On mem_ready: mem_read ← 0; install mem_data_in (valid=1, dirty=0); l1_data_out ← mem_data_in; l1_hit ← 0; go to RESPOND.

RESPOND:
- l1_ready is 1 for exactly this cycle; next state is IDLE.
- l1_data_out and l1_hit hold their values until the next response.

## Timing

- Request sampled at edge E. On a hit, l1_ready is high from E+1 to E+2; the earliest next request is sampled at E+3.
- A request held high across its own response is served once. L1 must drop it on the edge where it samples l1_ready.
- mem_read/mem_write:
  - Rise one edge after the state is entered.
  - Stay high, with address and data stable, until mem_ready is sampled high.
  - Fall at that same edge.
  - Never both high.
- Clean read miss latency: 2 + N cycles to l1_ready, where N is the memory wait. A dirty miss adds the write-back wait.
- Reset during WRITEBACK or FILL: mem_read/mem_write are 0 after the reset edge. No partial install occurs.

## Test plan

Memory model returns word i = 0xA000_0000+i, with mem_ready high 2 cycles after the request.
1. After reset, read 0x0000_0105 → mem_read with mem_addr=0x0000_0100, l1_hit=0, word 5 of l1_data_out = 0xA000_0005, single l1_ready pulse. Re-read 0x0000_0100 → l1_hit=1, l1_ready at E+1, no mem_read.
2. Write all-0x5555_5555 to 0x0000_0100 (hit) → l1_hit=1, no memory traffic. Reread returns 0x5555_5555.
3. Read 0x0000, 0x0400, 0x0800, 0x0C00 (set 0, ways 0–3), write-hit 0x0000, then read 0x1000 → mem_write at 0x0000 with 0x5555-style data precedes mem_read at 0x1000. Way 0 is replaced; rr_ptr=1.
4. Write miss to a set with a clean victim → no mem_read, l1_hit=0. Following read hits with the written data.
5. Assert rst_n=0 while mem_read is high in FILL → mem_read=0 after the edge, state IDLE. A read of the previously cached 0x0000_0100 misses.
6. Hold l1_read high through the response → exactly one mem_read burst and one l1_ready pulse per request.
